// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    localparam logic [3:0] COL_RESET  = 4'b1110;
    localparam int         DBNC_CNT_W = 4;
    localparam int         RPT_CNT_W  = 16;

    // Lowest-numbered low row wins when several rows are low together.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_to_idx(input logic [3:0] c);
        logic [1:0] idx;
        case (c)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] col_rotate(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan tick: one-cycle pulse every CLK_DIV clocks, down-counter with terminal compare.
module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= CNT_W'(CLK_DIV - 1);
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Firing at 1 rather than 0 gives a full period before the first tick after reset.
    assign tick = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce; optional auto-repeat under KEYPAD_REPEAT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_SCAN     | rotate col each tick until some row reads low
// ST_DEBOUNCE | col frozen, counting ticks the captured row stays low
// ST_PRESSED  | key accepted, key_held=1, waiting for the row to go high
// ST_RELEASE  | counting ticks the captured row stays high
module keypad_scan #(
    parameter int CLK_DIV      = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_CNT   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    if (CLK_DIV < 2 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT >= (1 << DBNC_CNT_W) ||
        REPEAT_CNT < 1 || REPEAT_CNT >= (1 << RPT_CNT_W)) begin : g_param_check
        $error("keypad_scan: parameter out of range");
    end

    localparam logic [DBNC_CNT_W-1:0] DBNC_TC = DBNC_CNT_W'(DEBOUNCE_CNT);

    logic                  tick;
    logic [3:0]            row_meta;
    logic [3:0]            row_sync;
    key_state_e            state_q, state_n;
    logic [3:0]            col_q, col_n;
    logic [1:0]            row_idx_q, row_idx_n;
    logic [DBNC_CNT_W-1:0] cnt_q, cnt_n;
    logic [DBNC_CNT_W-1:0] cnt_inc;
    logic [3:0]            key_code_q, key_code_n;
    logic                  key_valid_q, key_valid_n;
    logic [1:0]            scan_row;
    logic                  cap_high;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [RPT_CNT_W-1:0] RPT_TC = RPT_CNT_W'(REPEAT_CNT);
    logic [RPT_CNT_W-1:0] rpt_q, rpt_n;
    logic [RPT_CNT_W-1:0] rpt_inc;
`endif

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            col_q       <= COL_RESET;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_n;
            col_q       <= col_n;
            row_idx_q   <= row_idx_n;
            cnt_q       <= cnt_n;
            key_code_q  <= key_code_n;
            key_valid_q <= key_valid_n;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_n;
`endif
        end
    end

    assign scan_row = lowest_low_row(row_sync);
    assign cap_high = row_sync[row_idx_q];
    assign cnt_inc  = cnt_q + DBNC_CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
    assign rpt_inc  = rpt_q + RPT_CNT_W'(1);
`endif

    always_comb begin
        state_n     = state_q;
        col_n       = col_q;
        row_idx_n   = row_idx_q;
        cnt_n       = cnt_q;
        key_code_n  = key_code_q;
        key_valid_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_n       = rpt_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_sync != 4'hF) begin
                        row_idx_n = scan_row;
                        if (DEBOUNCE_CNT == 1) begin
                            state_n     = ST_PRESSED;
                            key_code_n  = {col_to_idx(col_q), scan_row};
                            key_valid_n = 1'b1;
                            cnt_n       = '0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_n       = '0;
`endif
                        end else begin
                            state_n = ST_DEBOUNCE;
                            cnt_n   = DBNC_CNT_W'(1);
                        end
                    end else begin
                        col_n = col_rotate(col_q);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cap_high) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DBNC_TC) begin
                            state_n     = ST_PRESSED;
                            key_code_n  = {col_to_idx(col_q), row_idx_q};
                            key_valid_n = 1'b1;
                            cnt_n       = '0;
`ifdef KEYPAD_REPEAT_EN
                            rpt_n       = '0;
`endif
                        end
                    end else begin
                        state_n = ST_SCAN;
                        col_n   = col_rotate(col_q);
                        cnt_n   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (cap_high) begin
                        // A single agreeing tick is already a debounced release.
                        if (DEBOUNCE_CNT == 1) begin
                            state_n = ST_SCAN;
                            col_n   = col_rotate(col_q);
                            cnt_n   = '0;
                        end else begin
                            state_n = ST_RELEASE;
                            cnt_n   = DBNC_CNT_W'(1);
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_inc == RPT_TC) begin
                            key_valid_n = 1'b1;
                            rpt_n       = '0;
                        end else begin
                            rpt_n = rpt_inc;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (cap_high) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DBNC_TC) begin
                            state_n = ST_SCAN;
                            col_n   = col_rotate(col_q);
                            cnt_n   = '0;
                        end
                    end else begin
                        state_n = ST_PRESSED;
                        cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rpt_n   = '0;
`endif
                    end
                end
                default: begin
                    state_n = ST_SCAN;
                    col_n   = COL_RESET;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboarded bench for keypad_scan driving a 4x4 switch-matrix model.
module tb_keypad_scan;

    localparam int CLK_DIV = 4;
    localparam int DBNC    = 3;
    localparam int RPT     = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          exp_q[$];
    logic [3:0]  mon_exp;

    always #5 clk = ~clk;

    // A closed switch at (c,r) pulls row r low only while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4 + r] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    keypad_scan #(
        .CLK_DIV      (CLK_DIV),
        .DEBOUNCE_CNT (DBNC),
        .REPEAT_CNT   (RPT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_key_valid got key_code=%0d expected no strobe", key_code);
            end else begin
                mon_exp = 4'(exp_q.pop_front());
                if (key_code !== mon_exp) begin
                    failures++;
                    $display("FAIL scoreboard_key_code got=%0d expected=%0d", key_code, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Land on the falling edge right after a tick has been acted on.
    task automatic sync_tick();
        do @(negedge clk); while (cyc % CLK_DIV != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) sync_tick();
    endtask

    task automatic wait_col(input logic [3:0] target, input string name);
        int n;
        n = 0;
        sync_tick();
        while (col !== target && n < 32) begin
            sync_tick();
            n++;
        end
        check(name, col, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_col", col, 4'b1110);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_held", key_held, 1'b0);
        check("reset_key_code", key_code, 4'd0);
        rst = 1'b0;

        // Idle: col dwells 4 clocks per column; first dwell ends at the 4th edge.
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << (((n + 1) / 4) % 4));
            check("idle_col", col, exp_col);
        end

        // Key 6: col 1101, row 1011.
        wait_col(4'b1101, "wait_col1_key6");
        pressed[6] = 1'b1;
        exp_q.push_back(6);
        sync_tick();
        check("key6_held_tick1", key_held, 1'b0);
        sync_tick();
        check("key6_valid_tick2", key_valid, 1'b0);
        sync_tick();
        check("key6_valid_tick3", key_valid, 1'b1);
        check("key6_code", key_code, 4'd6);
        check("key6_held", key_held, 1'b1);
        ticks(3);
        check("key6_col_frozen", col, 4'b1101);

        // One-tick release blip then re-press.
        pressed[6] = 1'b0;
        sync_tick();
        check("blip_held_in_release", key_held, 1'b1);
        pressed[6] = 1'b1;
        sync_tick();
        check("blip_held_back", key_held, 1'b1);
        sync_tick();
        pressed[6] = 1'b0;
        ticks(2);
        check("release_held_tick2", key_held, 1'b1);
        sync_tick();
        check("release_held_tick3", key_held, 1'b0);
        check("release_col_advanced", col, 4'b1011);

        // Two-tick glitch on key 12 (col 3, row 0).
        wait_col(4'b0111, "wait_col3_glitch");
        pressed[12] = 1'b1;
        sync_tick();
        check("glitch_col_frozen", col, 4'b0111);
        sync_tick();
        check("glitch_not_held", key_held, 1'b0);
        pressed[12] = 1'b0;
        sync_tick();
        check("glitch_col_resume", col, 4'b1110);
        check("glitch_held", key_held, 1'b0);

        // Keys 0 and 2 together at col 1110: row 0 wins.
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        exp_q.push_back(0);
        ticks(3);
        check("multi_code", key_code, 4'd0);
        check("multi_held", key_held, 1'b1);
        pressed[0] = 1'b0;
        pressed[2] = 1'b0;
        ticks(3);
        check("multi_released", key_held, 1'b0);

        // Reset in the middle of debouncing key 6.
        wait_col(4'b1101, "wait_col1_rst");
        pressed[6] = 1'b1;
        ticks(2);
        check("rst_pre_held", key_held, 1'b0);
        rst = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk);
        check("rst_mid_col", col, 4'b1110);
        check("rst_mid_valid", key_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_col", col, 4'b1110);
        check("rst_after_code", key_code, 4'd0);
        ticks(12);
        check("rst_after_held", key_held, 1'b0);

        // Key 15 held for 20 ticks from acceptance.
        wait_col(4'b0111, "wait_col3_key15");
        pressed[15] = 1'b1;
        exp_q.push_back(15);
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(15);
        exp_q.push_back(15);
        exp_q.push_back(15);
`endif
        ticks(3);
        check("key15_valid", key_valid, 1'b1);
        check("key15_code", key_code, 4'd15);
        ticks(19);
        check("key15_held", key_held, 1'b1);
        pressed[15] = 1'b0;
        ticks(3);
        check("key15_released", key_held, 1'b0);

        repeat (8) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving clk cycles per scan tick (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 4, giving consecutive agreeing ticks needed to accept a press or release (range 1..15).
REQ-003 The block SHALL have parameter REPEAT_CNT, default 100, giving ticks between auto-repeat pulses (used only under KEYPAD_REPEAT_EN).
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port row  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-007 The block SHALL have port col  output  4  column drive, active-low one-hot.
REQ-008 The block SHALL have port key_code  output  4  last accepted key, equal to col_idx*4 + row_idx.
REQ-009 The block SHALL have port key_valid  output  1  one-cycle strobe when key_code is updated or repeated.
REQ-010 The block SHALL have port key_held  output  1  high while an accepted key remains debounced-pressed.

Function
REQ-011 The block SHALL pass row through a two-flop synchronizer; all decisions use the synchronized value.
REQ-012 The block SHALL assert an internal tick for one clk cycle every CLK_DIV cycles, free-running from reset.
REQ-013 The block SHALL implement states SCAN, DEBOUNCE, PRESSED and RELEASE, evaluated only on tick cycles.
REQ-014 In SCAN, on each tick with no row low, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111, wrapping back to 1110.
REQ-015 In SCAN, on a tick with any row low, the block SHALL:
- capture col_idx and the lowest low row_idx (lowest index has priority);
- freeze col;
- set the count to 1 and enter DEBOUNCE.
REQ-016 In DEBOUNCE, on each tick:
- if the captured row is still low, the count SHALL increment;
- when the count reaches DEBOUNCE_CNT, the block SHALL enter PRESSED, load key_code and pulse key_valid in that same cycle;
- otherwise, if the captured row is high, the block SHALL return to SCAN and advance col.
REQ-017 If DEBOUNCE_CNT = 1, a press SHALL be accepted on the capturing tick itself, going directly SCAN -> PRESSED.
REQ-018 In PRESSED, key_held SHALL be 1 and col SHALL stay frozen; a tick with the captured row high SHALL set the count to 1 and enter RELEASE.
REQ-019 In RELEASE, on each tick:
- a tick with the captured row high SHALL increment the count;
- on reaching DEBOUNCE_CNT, the block SHALL go to SCAN, clear key_held and advance col;
- a tick with the captured row low SHALL return to PRESSED without a new key_valid.
REQ-020 Other keys pressed while in DEBOUNCE, PRESSED or RELEASE SHALL be ignored.
REQ-021 key_code SHALL hold its value until the next accepted press.

Reset
REQ-022 While rst=1, the block SHALL force:
- state=SCAN, col=1110, key_code=0, key_valid=0, key_held=0;
- tick divider and counts to 0;
- synchronizer flops to 1111.
REQ-023 A reset asserted mid-debounce or mid-hold SHALL abort that operation with no key_valid pulse; scanning SHALL restart from column 0 on the first cycle after rst deasserts.

Configuration
REQ-024 With macro KEYPAD_REPEAT_EN defined, the block SHALL re-pulse key_valid (same key_code) in PRESSED every REPEAT_CNT ticks after acceptance; the repeat count SHALL reset on entry to PRESSED, including the return from RELEASE.
REQ-025 Without KEYPAD_REPEAT_EN, the repeat counter SHALL NOT be built, and key_valid SHALL pulse exactly once per accepted press.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enumeration, the col reset constant 4'b1110 and the counter width constants.
REQ-027 The tick divider SHALL be a sub-module named scan_tick_gen (parameter CLK_DIV, ports clk, rst, tick).

Verification (CLK_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=5)
REQ-028 The bench SHALL cover: no key pressed for 40 cycles -> col sequence 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid stays 0.
REQ-029 The bench SHALL cover: row=1011 held while col=1101 -> key_code=4'd6 with a single key_valid on the 3rd agreeing tick, and key_held=1.
REQ-030 The bench SHALL cover: a 2-tick glitch on row[0] at col=0111 -> no key_valid; scanning resumes at 1110.
REQ-031 The bench SHALL cover: press key 6, then a 1-tick release blip -> key_held stays 1 with no second key_valid; full release for 3 ticks -> key_held=0.
REQ-032 The bench SHALL cover: rows 0 and 2 low together at col=1110 -> key_code=0; and rst pulsed mid-DEBOUNCE -> col=1110 and key_valid never asserted.
REQ-033 The bench SHALL cover, with KEYPAD_REPEAT_EN, key 15 held for 20 ticks -> key_valid pulses at acceptance and then every 5 ticks (4 pulses total).
